// File: rtl/dmem_responder_if.sv
// ---------------------------------------------------------------------------
// dmem_responder_if
// Purpose : LSU data-memory request/response bundle between the core's
//           load/store unit (master) and a data-memory target (slave).
// Signals :
//   req_valid  / req_ready  - request handshake (master -> slave)
//   req_we                  - 1 = store, 0 = load
//   req_addr   [31:0]       - byte address
//   req_wdata  [31:0]       - store data, right-aligned
//   req_funct3 [2:0]        - RV32I funct3 of the access
//   rsp_valid  / rsp_ready  - response handshake (slave -> master)
//   rsp_rdata  [31:0]       - extended load result, 0 for stores/errors
//   rsp_err                 - access rejected
// ---------------------------------------------------------------------------
interface dmem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [2:0]  req_funct3;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_funct3, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_funct3, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
// Purpose : Target end of the LSU request/response port. Accepts one load or
//           store at a time, waits LATENCY cycles, performs the word-array
//           access (RV32I byte/half/word lanes, sign/zero extension) and
//           returns a response, flagging misaligned, out-of-range and
//           illegal-funct3 accesses.
// Params  : ADDR_W  - word-address width (2**ADDR_W 32-bit words)
//           LATENCY - wait cycles between accept and response (0..15)
// Ports   : clk   - rising-edge clock
//           rst_n - asynchronous active-low reset
//           bus   - dmem_responder_if.slave (request/response handshakes)
// ---------------------------------------------------------------------------
module dmem_responder #(
   parameter int ADDR_W  = 10,
   parameter int LATENCY = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   dmem_responder_if.slave  bus
);

   generate
      if (LATENCY < 0 || LATENCY > 15) begin : g_latency_check
         $error("dmem_responder: LATENCY must be in 0..15");
      end
   endgenerate

   localparam bit         ZERO_LAT = (LATENCY == 0);
   localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t            state;
   state_t            state_nxt;
   logic [3:0]        cnt;

   logic              lat_we;
   logic [31:0]       lat_addr;
   logic [31:0]       lat_wdata;
   logic [2:0]        lat_funct3;

   logic              accept;
   logic              commit;

   logic              acc_we;
   logic [31:0]       acc_addr;
   logic [31:0]       acc_wdata;
   logic [2:0]        acc_funct3;
   logic [ADDR_W-1:0] acc_idx;
   logic              acc_err;
   logic [3:0]        acc_be;
   logic [31:0]       acc_wlane;
   logic [31:0]       acc_word;
   logic [31:0]       acc_load;

   logic [31:0]       rdata;
   logic              err;

   logic [31:0]       mem [0:(2**ADDR_W)-1];

   // -------------------------------------------------------------------------
   // Access-rule helpers
   // -------------------------------------------------------------------------
   function automatic logic access_err(input logic        we,
                                       input logic [31:0] addr,
                                       input logic [2:0]  f3);
      logic oor;
      logic mis;
      logic ill;
      oor = (addr >> (ADDR_W + 2)) != 32'd0;
      mis = ((f3[1:0] == 2'b01) && addr[0]) ||
            ((f3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
      if (we)
         ill = f3[2] || (f3[1:0] == 2'b11);   // only sb/sh/sw are stores
      else
         ill = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      return oor || mis || ill;
   endfunction

   function automatic logic [3:0] byte_en(input logic [2:0] f3,
                                          input logic [1:0] ofs);
      case (f3[1:0])
         2'b00:   return 4'b0001 << ofs;
         2'b01:   return ofs[1] ? 4'b1100 : 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

   // Replicate the right-aligned store data across lanes so the byte enables
   // alone decide which lanes land in memory.
   function automatic logic [31:0] store_lanes(input logic [2:0]  f3,
                                               input logic [31:0] wdata);
      case (f3[1:0])
         2'b00:   return {4{wdata[7:0]}};
         2'b01:   return {2{wdata[15:0]}};
         default: return wdata;
      endcase
   endfunction

   function automatic logic [31:0] load_extract(input logic [2:0]  f3,
                                                input logic [1:0]  ofs,
                                                input logic [31:0] word);
      logic signed [7:0]  b;
      logic signed [15:0] h;
      b = word[{ofs, 3'b000} +: 8];
      h = ofs[1] ? word[31:16] : word[15:0];
      case (f3)
         3'b000:  return 32'(b);            // lb: sign-extend
         3'b001:  return 32'(h);            // lh: sign-extend
         3'b100:  return {24'd0, b};        // lbu
         3'b101:  return {16'd0, h};        // lhu
         default: return word;              // lw
      endcase
   endfunction

   // -------------------------------------------------------------------------
   // FSM: state register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // -------------------------------------------------------------------------
   // FSM: next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.req_valid) state_nxt = ZERO_LAT ? RESP : WAIT;
         WAIT:    if (cnt == 4'd0)   state_nxt = RESP;
         RESP:    if (bus.rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // -------------------------------------------------------------------------
   // FSM: outputs
   // -------------------------------------------------------------------------
   always_comb begin
      bus.req_ready = (state == IDLE);
      bus.rsp_valid = (state == RESP);
      bus.rsp_rdata = rdata;
      bus.rsp_err   = err;
   end

   assign accept = (state == IDLE) && bus.req_valid;

   // The access commits on the edge that enters RESP. Gating with rst_n keeps
   // a zero-latency request presented during reset from reaching memory.
   assign commit = rst_n &&
                   ((ZERO_LAT && accept) || ((state == WAIT) && (cnt == 4'd0)));

   // -------------------------------------------------------------------------
   // Wait counter
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= 4'd0;
      else if (accept)
         cnt <= CNT_INIT;
      else if ((state == WAIT) && (cnt != 4'd0))
         cnt <= cnt - 4'd1;
   end

   // -------------------------------------------------------------------------
   // Request latch (data only, no reset needed: a reset returns to IDLE and
   // nothing is committed from stale contents)
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (accept) begin
         lat_we     <= bus.req_we;
         lat_addr   <= bus.req_addr;
         lat_wdata  <= bus.req_wdata;
         lat_funct3 <= bus.req_funct3;
      end
   end

   // With zero latency the commit edge is the accept edge, so the access is
   // taken straight from the bus instead of the latch.
   assign acc_we     = ZERO_LAT ? bus.req_we     : lat_we;
   assign acc_addr   = ZERO_LAT ? bus.req_addr   : lat_addr;
   assign acc_wdata  = ZERO_LAT ? bus.req_wdata  : lat_wdata;
   assign acc_funct3 = ZERO_LAT ? bus.req_funct3 : lat_funct3;

   assign acc_idx   = acc_addr[ADDR_W+1:2];
   assign acc_err   = access_err(acc_we, acc_addr, acc_funct3);
   assign acc_be    = byte_en(acc_funct3, acc_addr[1:0]);
   assign acc_wlane = store_lanes(acc_funct3, acc_wdata);
   assign acc_word  = mem[acc_idx];
   assign acc_load  = load_extract(acc_funct3, acc_addr[1:0], acc_word);

   // -------------------------------------------------------------------------
   // Memory array write
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (commit && acc_we && !acc_err) begin
         for (int i = 0; i < 4; i++) begin
            if (acc_be[i])
               mem[acc_idx][8*i +: 8] <= acc_wlane[8*i +: 8];
         end
      end
   end

   // -------------------------------------------------------------------------
   // Response registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata <= 32'd0;
         err   <= 1'b0;
      end else if (commit) begin
         err   <= acc_err;
         rdata <= (acc_err || acc_we) ? 32'd0 : acc_load;
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder
// Purpose : Directed self-checking bench for dmem_responder. Three instances
//           (LATENCY 1, 4 and 0) share the request fields; sel routes
//           req_valid/rsp_ready to one instance and muxes its outputs back.
// ---------------------------------------------------------------------------
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  sel = 2'd0;

   logic        valid = 1'b0;
   logic        we = 1'b0;
   logic [31:0] addr = 32'd0;
   logic [31:0] wdata = 32'd0;
   logic [2:0]  f3 = 3'd0;
   logic        rsp_ready = 1'b0;

   logic        mon_ready;
   logic        mon_rsp_valid;
   logic [31:0] mon_rdata;
   logic        mon_err;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   dmem_responder_if b1 ();
   dmem_responder_if b4 ();
   dmem_responder_if b0 ();

   assign b1.req_valid  = valid && (sel == 2'd0);
   assign b1.req_we     = we;
   assign b1.req_addr   = addr;
   assign b1.req_wdata  = wdata;
   assign b1.req_funct3 = f3;
   assign b1.rsp_ready  = rsp_ready && (sel == 2'd0);

   assign b4.req_valid  = valid && (sel == 2'd1);
   assign b4.req_we     = we;
   assign b4.req_addr   = addr;
   assign b4.req_wdata  = wdata;
   assign b4.req_funct3 = f3;
   assign b4.rsp_ready  = rsp_ready && (sel == 2'd1);

   assign b0.req_valid  = valid && (sel == 2'd2);
   assign b0.req_we     = we;
   assign b0.req_addr   = addr;
   assign b0.req_wdata  = wdata;
   assign b0.req_funct3 = f3;
   assign b0.rsp_ready  = rsp_ready && (sel == 2'd2);

   dmem_responder #(.ADDR_W(10), .LATENCY(1)) u_lat1 (.clk(clk), .rst_n(rst_n), .bus(b1));
   dmem_responder #(.ADDR_W(10), .LATENCY(4)) u_lat4 (.clk(clk), .rst_n(rst_n), .bus(b4));
   dmem_responder #(.ADDR_W(10), .LATENCY(0)) u_lat0 (.clk(clk), .rst_n(rst_n), .bus(b0));

   always_comb begin
      case (sel)
         2'd1: begin
            mon_ready = b4.req_ready; mon_rsp_valid = b4.rsp_valid;
            mon_rdata = b4.rsp_rdata; mon_err = b4.rsp_err;
         end
         2'd2: begin
            mon_ready = b0.req_ready; mon_rsp_valid = b0.rsp_valid;
            mon_rdata = b0.rsp_rdata; mon_err = b0.rsp_err;
         end
         default: begin
            mon_ready = b1.req_ready; mon_rsp_valid = b1.rsp_valid;
            mon_rdata = b1.rsp_rdata; mon_err = b1.rsp_err;
         end
      endcase
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Accept-to-rsp_valid cycles for the selected instance: LATENCY+1.
   function automatic int exp_lat(input logic [1:0] s);
      case (s)
         2'd1:    return 5;
         2'd2:    return 1;
         default: return 2;
      endcase
   endfunction

   // One complete transaction. Called just after a rising edge.
   task automatic do_req(input string tag, input logic we_i, input logic [2:0] f3_i,
                         input logic [31:0] addr_i, input logic [31:0] wdata_i,
                         input logic [31:0] exp_rdata, input logic exp_err);
      int n;
      check({tag, ":ready_idle"}, 32'(mon_ready), 32'd1);
      valid = 1'b1; we = we_i; f3 = f3_i; addr = addr_i; wdata = wdata_i;
      @(posedge clk); #1;
      // Scramble the request fields: they must be ignored from here on.
      valid = 1'b0; we = ~we_i; f3 = 3'b111; addr = 32'hFFFF_FFFF; wdata = ~wdata_i;
      check({tag, ":ready_drop"}, 32'(mon_ready), 32'd0);
      n = 1;
      while (!mon_rsp_valid && n < 30) begin
         @(posedge clk); #1;
         n++;
      end
      check({tag, ":latency"}, 32'(n), 32'(exp_lat(sel)));
      check({tag, ":rdata"}, mon_rdata, exp_rdata);
      check({tag, ":err"}, 32'(mon_err), 32'(exp_err));
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      check({tag, ":rsp_done"}, 32'(mon_rsp_valid), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      sel = 2'd0;
      rst_n = 1'b0;
      #3;
      check("rst_ready", 32'(mon_ready), 32'd1);
      check("rst_rsp_valid", 32'(mon_rsp_valid), 32'd0);
      check("rst_rdata", mon_rdata, 32'd0);
      check("rst_err", 32'(mon_err), 32'd0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      // Word store/load, LATENCY=1
      do_req("sw10",   1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
      do_req("lw10",   1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

      // Byte lane store and extensions
      do_req("sb11",   1'b1, 3'b000, 32'h11, 32'h000000A5, 32'h0, 1'b0);
      do_req("lb11",   1'b0, 3'b000, 32'h11, 32'h0, 32'hFFFFFFA5, 1'b0);
      do_req("lbu11",  1'b0, 3'b100, 32'h11, 32'h0, 32'h000000A5, 1'b0);
      do_req("lw10b",  1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADA5EF, 1'b0);
      do_req("lb12",   1'b0, 3'b000, 32'h12, 32'h0, 32'hFFFFFFAD, 1'b0);

      // Half lane store and extensions
      do_req("sw20",   1'b1, 3'b010, 32'h20, 32'h13572468, 32'h0, 1'b0);
      do_req("sh22",   1'b1, 3'b001, 32'h22, 32'h00008001, 32'h0, 1'b0);
      do_req("lh22",   1'b0, 3'b001, 32'h22, 32'h0, 32'hFFFF8001, 1'b0);
      do_req("lhu22",  1'b0, 3'b101, 32'h22, 32'h0, 32'h00008001, 1'b0);
      do_req("lw20",   1'b0, 3'b010, 32'h20, 32'h0, 32'h80012468, 1'b0);
      do_req("lh20",   1'b0, 3'b001, 32'h20, 32'h0, 32'h00002468, 1'b0);

      // Error cases
      do_req("lw13",   1'b0, 3'b010, 32'h13, 32'h0, 32'h0, 1'b1);
      do_req("sh21",   1'b1, 3'b001, 32'h21, 32'h0000FFFF, 32'h0, 1'b1);
      do_req("lw20c",  1'b0, 3'b010, 32'h20, 32'h0, 32'h80012468, 1'b0);
      do_req("lw1000", 1'b0, 3'b010, 32'h1000, 32'h0, 32'h0, 1'b1);
      do_req("ld011",  1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1);
      do_req("st100",  1'b1, 3'b100, 32'h10, 32'h0, 32'h0, 1'b1);
      do_req("lw10c",  1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADA5EF, 1'b0);
      do_req("swFFC",  1'b1, 3'b010, 32'hFFC, 32'h0BADCAFE, 32'h0, 1'b0);
      do_req("lwFFC",  1'b0, 3'b010, 32'hFFC, 32'h0, 32'h0BADCAFE, 1'b0);

      // Backpressure: response held while rsp_ready=0, second request refused
      valid = 1'b1; we = 1'b0; f3 = 3'b010; addr = 32'h10; wdata = 32'h0;
      @(posedge clk); #1;
      valid = 1'b0;
      @(posedge clk); #1;
      check("bp_valid_up", 32'(mon_rsp_valid), 32'd1);
      valid = 1'b1; we = 1'b1; f3 = 3'b010; addr = 32'h10; wdata = 32'h0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("bp_rsp_valid", 32'(mon_rsp_valid), 32'd1);
         check("bp_rdata", mon_rdata, 32'hDEADA5EF);
         check("bp_ready", 32'(mon_ready), 32'd0);
      end
      valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      check("bp_release_valid", 32'(mon_rsp_valid), 32'd0);
      check("bp_release_ready", 32'(mon_ready), 32'd1);
      do_req("bp_lw10", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADA5EF, 1'b0);

      // Reset mid-operation, LATENCY=4
      sel = 2'd1;
      #1;
      do_req("l4_sw30", 1'b1, 3'b010, 32'h30, 32'hCAFEF00D, 32'h0, 1'b0);
      do_req("l4_lw13", 1'b0, 3'b010, 32'h13, 32'h0, 32'h0, 1'b1);
      valid = 1'b1; we = 1'b1; f3 = 3'b010; addr = 32'h30; wdata = 32'h12345678;
      @(posedge clk); #1;
      valid = 1'b0;
      @(posedge clk); #1;
      check("l4_in_wait", 32'(mon_rsp_valid), 32'd0);
      rst_n = 1'b0;
      #1;
      check("l4_rst_ready", 32'(mon_ready), 32'd1);
      check("l4_rst_rsp_valid", 32'(mon_rsp_valid), 32'd0);
      check("l4_rst_rdata", mon_rdata, 32'd0);
      check("l4_rst_err", 32'(mon_err), 32'd0);
      @(negedge clk); rst_n = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      check("l4_idle_after", 32'(mon_rsp_valid), 32'd0);
      do_req("l4_lw30", 1'b0, 3'b010, 32'h30, 32'h0, 32'hCAFEF00D, 1'b0);

      // LATENCY=0
      sel = 2'd2;
      #1;
      do_req("l0_sw40",   1'b1, 3'b010, 32'h40, 32'h000055AA, 32'h0, 1'b0);
      do_req("l0_lhu40",  1'b0, 3'b101, 32'h40, 32'h0, 32'h000055AA, 1'b0);
      do_req("l0_lb40",   1'b0, 3'b000, 32'h40, 32'h0, 32'hFFFFFFAA, 1'b0);
      do_req("l0_lw1000", 1'b0, 3'b010, 32'h1000, 32'h0, 32'h0, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the core's load/store port; the target end of the LSU request/response interface.
- Accepts one request at a time (load or store), waits a programmable latency, performs the word-array access, then returns a response.
- Handles RV32I sb/sh/sw byte-lane writes, lb/lh/lw/lbu/lhu extraction with sign/zero extension, and misaligned, out-of-range or illegal-funct3 error reporting.

Parameters:
- ADDR_W, 10, word-address width; memory holds 2**ADDR_W 32-bit words; valid byte addresses are 0 .. 4*2**ADDR_W-1.
- LATENCY, 1, wait cycles between request acceptance and response (0..15).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- req_funct3  in  3  RV32I funct3 of the load/store
- rsp_valid  out  1  response present
- rsp_ready  in  1  requester accepts response
- rsp_rdata  out  32  load result, extended; 0 for stores and errors
- rsp_err  out  1  access rejected

Behaviour:
- Reset (async, rst_n=0): state IDLE; req_ready=1; rsp_valid=0; rsp_rdata=0; rsp_err=0; wait counter=0. Memory contents are not reset.
- Reset mid-operation discards any latched request. A store not yet committed is never written.

States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - req_valid&req_ready latches we/addr/wdata/funct3.
  - If LATENCY=0, goes to RESP; otherwise loads the counter with LATENCY-1 and goes to WAIT.
- WAIT:
  - req_ready=0.
  - Counter decrements each cycle.
  - When counter=0, goes to RESP.
- Access commit:
  - Happens on the clock edge entering RESP.
  - Stores write memory and loads register rsp_rdata/rsp_err on that edge.
  - Accept-to-rsp_valid latency is LATENCY+1 cycles.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err are held stable until rsp_valid&rsp_ready.
  - Then goes to IDLE with rsp_valid=0.
  - req_ready=0 while in RESP; there is no same-cycle accept, so at most one request is outstanding.
  - rsp_ready=0 stalls indefinitely with no state change.

Error rules (rsp_err=1, no memory write, rsp_rdata=0):
- Misaligned: half (funct3[1:0]=01) with addr[0]=1, or word (10) with addr[1:0]!=0.
- Out of range: addr[31:ADDR_W+2] != 0.
- Illegal funct3:
  - Loads: 011, 110, 111.
  - Stores: anything other than 000, 001, 010.

Store lanes:
- sb writes byte addr[1:0] with wdata[7:0].
- sh writes lanes {addr[1],0} and +1 with wdata[15:0].
- sw writes all four lanes.
- Unwritten lanes are unchanged.

Load extraction:
- Word index = addr[ADDR_W+1:2].
- lb/lbu select byte addr[1:0]; lh/lhu select half addr[1].
- lb/lh sign-extend from bit 7/15; lbu/lhu zero-extend.
- lw returns the word unchanged.
- Stores respond with rsp_rdata=0, rsp_err=0.

Other rules:
- Input changes on req_* outside an accepting cycle are ignored.
- Counter width is 4 bits; LATENCY>15 is illegal and is flagged by an elaboration-time check.

Test Plan:
- Reset then sw addr=0x10 wdata=0xDEADBEEF, LATENCY=1 -> req_ready drops the cycle after accept, rsp_valid 2 cycles after accept, rsp_err=0, rsp_rdata=0; following lw 0x10 returns 0xDEADBEEF.
- After the above, sb 0x11 wdata=0x000000A5, then lb 0x11 -> 0xFFFFFFA5; lbu 0x11 -> 0x000000A5; lw 0x10 -> 0xDEADA5EF.
- sh 0x22 wdata=0x8001 then lh 0x22 -> 0xFFFF8001; lhu 0x22 -> 0x00008001; lw 0x20 -> 0x8001xxxx, with the low half unchanged from its prior value.
- Errors: lw 0x13 -> rsp_err=1, rsp_rdata=0; sh 0x21 -> rsp_err=1 and a later lw 0x20 is unchanged; lw 0x1000 with ADDR_W=10 -> rsp_err=1; load funct3=011 -> rsp_err=1.
- Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_valid stays 1, data stable, req_ready=0, a second req_valid is not accepted; release -> one handshake, then IDLE with req_ready=1.
- Reset mid-op: accept sw 0x30 wdata=0x12345678 with LATENCY=4, assert rst_n=0 during WAIT -> outputs at reset values immediately; later lw 0x30 returns the pre-existing value, not 0x12345678. With LATENCY=0: rsp_valid is 1 cycle after accept.
